// File: rtl/axi4_wr_burst_track_pkg.sv
// Shared types and constants for the AXI4 write-burst tracker: BRESP encodings,
// the packed record of sticky error flags and a saturating beat-count helper.
package axi4_wr_burst_track_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef struct packed {
        logic wr_overflow;
        logic len_error;
        logic wrong_id;
        logic orphan_b;
        logic timeout_error;
    } wr_track_err_t;

    function automatic logic [8:0] sat_inc9(input logic [8:0] value);
        return (value == 9'h1FF) ? value : value + 9'd1;
    endfunction

endpackage

// File: rtl/axi4_wr_burst_track_fifo.sv
// First-word-fall-through FIFO used for the AW, WLEN and B tracking queues.
// Pushes to a full FIFO and pops from an empty FIFO are dropped.
module track_fifo #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DSIZE-1:0] din,
    input  logic             pop,
    output logic [DSIZE-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi4_wr_burst_track.sv
// Passive AXI4 write-path monitor: checks beat counts, B ordering/IDs, outstanding
// overflow, orphan B and response timeout. Define AXI4_WR_TRACK_SIM_EN for $error reporting.
module axi4_wr_burst_track
    import axi4_wr_burst_track_pkg::*;
#(
    parameter int IDSIZE    = 4,
    parameter int MAX_LEN   = 16,
    parameter int MAX_CYCLE = 1000,
    parameter int DEPTH     = 32
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [IDSIZE-1:0] axi_awid,
    input  logic [7:0]        axi_awlen,
    input  logic              axi_awvalid,
    input  logic              axi_awready,
    input  logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic              axi_wlast,
    input  logic [IDSIZE-1:0] axi_bid,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    input  logic              axi_bready,
    output logic              wr_overflow,
    output logic              len_error,
    output logic              wrong_id,
    output logic              orphan_b,
    output logic              timeout_error
);

    logic awh, wh, wlh, bh;
    logic [8:0]  wbeat;
    logic [8:0]  beat_live;
    logic [15:0] outstanding;
    logic [15:0] out_next;
    logic [15:0] tcnt;
    logic [7:0]  last_awlen;

    logic [IDSIZE+7:0] aw_dout;
    logic              aw_full, aw_empty, aw_push, aw_pop;
    logic [8:0]        wl_dout;
    logic              wl_full, wl_empty, wl_push, wl_pop;
    logic [IDSIZE-1:0] b_dout;
    logic              b_full, b_empty, b_pop;

    logic              pair;
    logic [IDSIZE-1:0] pair_id;
    logic [7:0]        pair_len;
    logic [8:0]        pair_cnt;

    wr_track_err_t err;
    wr_track_err_t err_set;

    assign awh       = axi_awvalid && axi_awready;
    assign wh        = axi_wvalid && axi_wready;
    assign wlh       = wh && axi_wlast;
    assign bh        = axi_bvalid && axi_bready;
    assign beat_live = sat_inc9(wbeat);

    // An empty FIFO whose handshake fires this cycle forwards the live value
    // instead of being pushed, so pairing lands on the later of AW and WLAST.
    assign pair    = (!aw_empty || awh) && (!wl_empty || wlh);
    assign aw_push = awh && !(aw_empty && pair);
    assign aw_pop  = pair && !aw_empty;
    assign wl_push = wlh && !(wl_empty && pair);
    assign wl_pop  = pair && !wl_empty;
    assign b_pop   = bh && !b_empty;

    always_comb begin
        pair_id  = aw_empty ? axi_awid  : aw_dout[IDSIZE+7:8];
        pair_len = aw_empty ? axi_awlen : aw_dout[7:0];
        pair_cnt = wl_empty ? beat_live : wl_dout;
    end

    always_comb begin
        out_next = outstanding;
        if (awh && !bh && outstanding != 16'hFFFF)
            out_next = outstanding + 16'd1;
        else if (bh && !awh && outstanding != 16'd0)
            out_next = outstanding - 16'd1;
    end

    always_comb begin
        err_set.wr_overflow   = (out_next > 16'(MAX_LEN)) ||
                                (aw_push && aw_full) || (wl_push && wl_full) || (pair && b_full);
        err_set.len_error     = pair && (pair_cnt != ({1'b0, pair_len} + 9'd1));
        err_set.wrong_id      = b_pop && (b_dout != axi_bid);
        err_set.orphan_b      = bh && b_empty;
        err_set.timeout_error = ({1'b0, tcnt} >= (17'(MAX_CYCLE) + {9'd0, last_awlen}));
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wbeat       <= '0;
            outstanding <= '0;
            tcnt        <= '0;
            last_awlen  <= '0;
            err         <= '0;
        end else begin
            if (wlh)
                wbeat <= '0;
            else if (wh)
                wbeat <= beat_live;
            outstanding <= out_next;
            if (bh || outstanding == 16'd0)
                tcnt <= '0;
            else if (tcnt != 16'hFFFF)
                tcnt <= tcnt + 16'd1;
            if (awh)
                last_awlen <= axi_awlen;
            err <= err | err_set;
        end
    end

    assign wr_overflow   = err.wr_overflow;
    assign len_error     = err.len_error;
    assign wrong_id      = err.wrong_id;
    assign orphan_b      = err.orphan_b;
    assign timeout_error = err.timeout_error;

    track_fifo #(.DSIZE(IDSIZE + 8), .DEPTH(DEPTH)) u_aw_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (aw_push),
        .din   ({axi_awid, axi_awlen}),
        .pop   (aw_pop),
        .dout  (aw_dout),
        .full  (aw_full),
        .empty (aw_empty)
    );

    track_fifo #(.DSIZE(9), .DEPTH(DEPTH)) u_wlen_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (wl_push),
        .din   (beat_live),
        .pop   (wl_pop),
        .dout  (wl_dout),
        .full  (wl_full),
        .empty (wl_empty)
    );

    track_fifo #(.DSIZE(IDSIZE), .DEPTH(DEPTH)) u_b_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (pair),
        .din   (pair_id),
        .pop   (b_pop),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

`ifdef AXI4_WR_TRACK_SIM_EN
    wr_track_err_t     err_q;
    logic [IDSIZE-1:0] exp_id_q;
    logic [IDSIZE-1:0] act_id_q;

    always @(posedge axi_aclk) begin
        err_q <= err;
        if (err_set.wrong_id && !err.wrong_id) begin
            exp_id_q <= b_dout;
            act_id_q <= axi_bid;
        end
        if ((err & ~err_q) != '0) begin
            if (err.wr_overflow && !err_q.wr_overflow)
                $error("wr_overflow at %0t", $time);
            if (err.len_error && !err_q.len_error)
                $error("len_error at %0t", $time);
            if (err.wrong_id && !err_q.wrong_id)
                $error("wrong_id at %0t: expected %0d got %0d", $time, exp_id_q, act_id_q);
            if (err.orphan_b && !err_q.orphan_b)
                $error("orphan_b at %0t", $time);
            if (err.timeout_error && !err_q.timeout_error)
                $error("timeout_error at %0t", $time);
            #1us;
            $stop;
        end
    end

    logic unused_bresp;
    assign unused_bresp = ^axi_bresp;
`else
    logic unused_bresp;
    assign unused_bresp = ^axi_bresp;
`endif

endmodule
